sample_fifo: RTL and testbench



---
 rtl/sample_fifo_pkg.sv | 24 ++
 rtl/sample_fifo_if.sv | 32 +++
 rtl/sample_fifo_ram.sv | 43 ++++
 rtl/sample_fifo.sv | 102 ++++++++++
 tb/tb_sample_fifo.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/sample_fifo_pkg.sv
// Shared defaults, width helper and status type for the sample FIFO.
package sample_fifo_pkg;

    localparam int DW_DEFAULT    = 16;
    localparam int DEPTH_DEFAULT = 64;

    // Smallest r with 2**r >= value; written as a bounded loop so it elaborates anywhere.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } fifo_status_t;

endpackage

// File: rtl/sample_fifo_if.sv
// Data, handshake and status bundle between a FIFO user (master) and the FIFO (slave).
interface sample_fifo_if import sample_fifo_pkg::*; #(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
);
    localparam int CW = log2(DEPTH) + 1;

    logic          sclr;
    logic          clr_err;
    logic [DW-1:0] data;
    logic          wrreq;
    logic          rdreq;
    logic [DW-1:0] q;
    logic [CW-1:0] usedw;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic          overflow;
    logic          underflow;

    modport master (
        output sclr, clr_err, data, wrreq, rdreq,
        input  q, usedw, empty, full, almost_empty, almost_full, overflow, underflow
    );

    modport slave (
        input  sclr, clr_err, data, wrreq, rdreq,
        output q, usedw, empty, full, almost_empty, almost_full, overflow, underflow
    );

endinterface

// File: rtl/sample_fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read (normal) or direct read (show-ahead).
module fifo_ram import sample_fifo_pkg::*; #(
    parameter int DW        = DW_DEFAULT,
    parameter int AW        = log2(DEPTH_DEFAULT),
    parameter int SHOWAHEAD = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    // NOTE: storage carries no reset so it can map onto RAM primitives; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    generate
        if (SHOWAHEAD == 0) begin : g_registered
            logic [DW-1:0] rd_q;

            // A same-edge write to rd_addr returns the old word (read-before-write).
            always_ff @(posedge clk) begin
                if (rst)        rd_q <= '0;
                else if (rd_en) rd_q <= mem[rd_addr];
            end

            assign rd_data = rd_q;
        end else begin : g_showahead
            logic unused_ctrl;

            assign unused_ctrl = rd_en ^ rst;
            assign rd_data     = mem[rd_addr];
        end
    endgenerate

endmodule

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO: pointer/count control, status flags and sticky error flags around fifo_ram.
module sample_fifo import sample_fifo_pkg::*; #(
    parameter int DW        = DW_DEFAULT,
    parameter int DEPTH     = DEPTH_DEFAULT,
    parameter int AE_LEVEL  = 2,
    parameter int AF_LEVEL  = DEPTH - 4,
    parameter int SHOWAHEAD = 0
) (
    input  logic           clk,
    input  logic           rst_geral,
    sample_fifo_if.slave   bus
);

    localparam int AW = log2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;
    logic          wr_en;
    logic          rd_en;
    logic          ovf_evt;
    logic          udf_evt;
    logic [DW-1:0] ram_q;
    fifo_status_t  status;

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        status.empty        = (count == '0);
        status.full         = (count == CW'(DEPTH));
        status.almost_empty = (count <= CW'(AE_LEVEL));
        status.almost_full  = (count >= CW'(AF_LEVEL));

        // A rejected read on empty does not block a same-cycle write.
        rd_en   = bus.rdreq && !status.empty && !bus.sclr;
        wr_en   = bus.wrreq && (!status.full || bus.rdreq) && !bus.sclr;
        ovf_evt = bus.wrreq && !wr_en && !bus.sclr;
        udf_evt = bus.rdreq && status.empty && !bus.sclr;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (rst_geral || bus.sclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_geral || bus.clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt) overflow  <= 1'b1;
            if (udf_evt) underflow <= 1'b1;
        end
    end

    fifo_ram #(
        .DW        (DW),
        .AW        (AW),
        .SHOWAHEAD (SHOWAHEAD)
    ) u_ram (
        .clk     (clk),
        .rst     (rst_geral),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (bus.data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    generate
        if (SHOWAHEAD != 0) begin : g_q_showahead
            // Forced to zero while empty: stable, and matches the reset value.
            assign bus.q = status.empty ? '0 : ram_q;
        end else begin : g_q_normal
            assign bus.q = ram_q;
        end
    endgenerate

    assign bus.usedw        = count;
    assign bus.empty        = status.empty;
    assign bus.full         = status.full;
    assign bus.almost_empty = status.almost_empty;
    assign bus.almost_full  = status.almost_full;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;

endmodule

// File: tb/tb_sample_fifo.sv
// Scoreboard bench driving a normal-mode and a show-ahead sample_fifo with identical stimulus.
module tb_sample_fifo;
    import sample_fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_geral;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];

    always #5 clk = ~clk;

    sample_fifo_if #(.DW(16), .DEPTH(64)) bus_a ();
    sample_fifo_if #(.DW(16), .DEPTH(64)) bus_b ();

    sample_fifo #(.DW(16), .DEPTH(64), .AE_LEVEL(2), .AF_LEVEL(60), .SHOWAHEAD(0)) dut_a (
        .clk       (clk),
        .rst_geral (rst_geral),
        .bus       (bus_a)
    );

    sample_fifo #(.DW(16), .DEPTH(64), .AE_LEVEL(2), .AF_LEVEL(60), .SHOWAHEAD(1)) dut_b (
        .clk       (clk),
        .rst_geral (rst_geral),
        .bus       (bus_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int i);
        return 16'(32'h4000 + i * 37);
    endfunction

    // Drive one cycle at the falling edge; return just after the next rising edge.
    task automatic step(input logic w, input logic [15:0] d, input logic r,
                        input logic s = 1'b0, input logic c = 1'b0, input logic rs = 1'b0);
        @(negedge clk);
        bus_a.wrreq = w;  bus_b.wrreq = w;
        bus_a.data  = d;  bus_b.data  = d;
        bus_a.rdreq = r;  bus_b.rdreq = r;
        bus_a.sclr  = s;  bus_b.sclr  = s;
        bus_a.clr_err = c; bus_b.clr_err = c;
        rst_geral = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_push(input logic [15:0] v);
        exp_a.push_back(v);
        exp_b.push_back(v);
        step(1'b0, 16'h0, 1'b1);
    endtask

    // Normal mode: popped word appears on q after the accepting edge.
    initial begin
        logic fire;
        forever begin
            @(negedge clk);
            #1;
            fire = bus_a.rdreq && !bus_a.empty && !bus_a.sclr && !rst_geral;
            @(posedge clk);
            #1;
            if (fire) begin
                if (exp_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL q_a unexpected pop actual=%0h", bus_a.q);
                end else begin
                    check("q_a", 32'(bus_a.q), 32'(exp_a.pop_front()));
                end
            end
        end
    end

    // Show-ahead: the head word is on q while the read is being requested.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (bus_b.rdreq && !bus_b.empty && !bus_b.sclr && !rst_geral) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL q_b unexpected pop actual=%0h", bus_b.q);
                end else begin
                    check("q_b", 32'(bus_b.q), 32'(exp_b.pop_front()));
                end
            end
        end
    end

    initial begin
        bus_a.wrreq = 1'b0; bus_a.rdreq = 1'b0; bus_a.data = '0; bus_a.sclr = 1'b0; bus_a.clr_err = 1'b0;
        bus_b.wrreq = 1'b0; bus_b.rdreq = 1'b0; bus_b.data = '0; bus_b.sclr = 1'b0; bus_b.clr_err = 1'b0;
        rst_geral = 1'b1;

        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_usedw", 32'(bus_a.usedw), 0);
        check("rst_empty", 32'(bus_a.empty), 1);
        check("rst_full", 32'(bus_a.full), 0);
        check("rst_ae", 32'(bus_a.almost_empty), 1);
        check("rst_af", 32'(bus_a.almost_full), 0);
        check("rst_ovf", 32'(bus_a.overflow), 0);
        check("rst_udf", 32'(bus_a.underflow), 0);
        check("rst_q_a", 32'(bus_a.q), 0);
        check("rst_q_b", 32'(bus_b.q), 0);
        check("rst_empty_b", 32'(bus_b.empty), 1);

        // Scenario 1: three words in, three out in order (-11172 = 0xD45C).
        step(1'b1, 16'hD45C, 1'b0);
        check("s1_usedw1", 32'(bus_a.usedw), 1);
        check("s1_empty0", 32'(bus_a.empty), 0);
        step(1'b1, 16'h0005, 1'b0);
        check("s1_usedw2", 32'(bus_a.usedw), 2);
        step(1'b1, 16'h0007, 1'b0);
        check("s1_usedw3", 32'(bus_a.usedw), 3);
        check("s1_ae0", 32'(bus_a.almost_empty), 0);
        check("s1_head_b", 32'(bus_b.q), 32'h0000D45C);
        rd_push(16'hD45C);
        check("s1_usedw_rd", 32'(bus_a.usedw), 2);
        rd_push(16'h0005);
        rd_push(16'h0007);
        check("s1_usedw0", 32'(bus_a.usedw), 0);
        check("s1_empty1", 32'(bus_a.empty), 1);

        // Scenario 5: show-ahead presents a fresh word without a read request.
        step(1'b1, 16'd100, 1'b0);
        check("s5_q_b", 32'(bus_b.q), 100);
        check("s5_empty_b", 32'(bus_b.empty), 0);
        step(1'b0, 16'h0, 1'b0);
        check("s5_q_b_hold", 32'(bus_b.q), 100);
        rd_push(16'd100);
        check("s5_empty_b1", 32'(bus_b.empty), 1);

        // Scenario 2: fill to capacity, then one write too many.
        for (int i = 0; i < 64; i++) begin
            step(1'b1, pat(i), 1'b0);
            if (i == 58) check("s2_af_59", 32'(bus_a.almost_full), 0);
            if (i == 59) check("s2_af_60", 32'(bus_a.almost_full), 1);
            if (i == 62) check("s2_full_63", 32'(bus_a.full), 0);
        end
        check("s2_full_64", 32'(bus_a.full), 1);
        check("s2_usedw64", 32'(bus_a.usedw), 64);
        step(1'b1, 16'hBEEF, 1'b0);
        check("s2_ovf", 32'(bus_a.overflow), 1);
        check("s2_ovf_b", 32'(bus_b.overflow), 1);
        check("s2_usedw_ovf", 32'(bus_a.usedw), 64);
        step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1);
        check("s2_clr_prio", 32'(bus_a.overflow), 0);

        // Scenario 3: read+write at full; 0x1234 must come out 64th, after the pointers wrap.
        exp_a.push_back(pat(0));
        exp_b.push_back(pat(0));
        step(1'b1, 16'h1234, 1'b1);
        check("s3_usedw64", 32'(bus_a.usedw), 64);
        check("s3_ovf0", 32'(bus_a.overflow), 0);
        for (int i = 1; i < 64; i++) rd_push(pat(i));
        rd_push(16'h1234);
        check("s3_empty", 32'(bus_a.empty), 1);
        check("s3_usedw0", 32'(bus_b.usedw), 0);

        // Scenario 4: read on empty with a same-cycle write.
        step(1'b1, 16'h0055, 1'b1);
        check("s4_udf", 32'(bus_a.underflow), 1);
        check("s4_udf_b", 32'(bus_b.underflow), 1);
        check("s4_usedw1", 32'(bus_a.usedw), 1);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        check("s4_clr", 32'(bus_a.underflow), 0);
        rd_push(16'h0055);

        // Scenario 6: flush keeps error flags, reset mid-burst clears everything.
        step(1'b0, 16'h0, 1'b1);
        check("s6_udf", 32'(bus_a.underflow), 1);
        for (int i = 0; i < 30; i++) step(1'b1, pat(i), 1'b0);
        check("s6_usedw30", 32'(bus_a.usedw), 30);
        step(1'b1, 16'hAAAA, 1'b1, 1'b1);
        check("s6_sclr_usedw", 32'(bus_a.usedw), 0);
        check("s6_sclr_empty", 32'(bus_a.empty), 1);
        check("s6_sclr_udf", 32'(bus_a.underflow), 1);
        check("s6_sclr_ovf", 32'(bus_a.overflow), 0);
        step(1'b1, 16'h7777, 1'b0);
        rd_push(16'h7777);
        step(1'b1, 16'h0001, 1'b0);
        step(1'b1, 16'h0002, 1'b0);
        step(1'b1, 16'h0003, 1'b1, 1'b0, 1'b0, 1'b1);
        check("s6_rst_usedw", 32'(bus_a.usedw), 0);
        check("s6_rst_empty", 32'(bus_a.empty), 1);
        check("s6_rst_udf", 32'(bus_a.underflow), 0);
        check("s6_rst_q_a", 32'(bus_a.q), 0);
        check("s6_rst_q_b", 32'(bus_b.q), 0);
        step(1'b0, 16'h0, 1'b0);
        check("s6_idle_usedw", 32'(bus_b.usedw), 0);

        check("sb_a_drained", 32'(exp_a.size()), 0);
        check("sb_b_drained", 32'(exp_b.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
